scaler_frame_ctrl: RTL and testbench
====================================

SCALER_FRAME_CTRL -- requirements
Module: scaler_frame_ctrl

Interface
REQ-001 Parameter C_IN_PORT_NUM, default 16: pixels per input FIFO beat.
REQ-002 Parameter C_CNT_WIDTH, default 32: beat counter width.
REQ-003 CLK_I  in  1  single clock; all logic synchronous to its rising edge.
REQ-004 RST_I  in  1  reset, synchronous, active-high.
REQ-005 VS_I  in  1  frame sync level; rising edge marks frame boundary.
REQ-006 CFG_HACTIVE_I / CFG_VACTIVE_I  in  16 each  requested input width/height in pixels/lines.
REQ-007 CFG_SCALE_ENABLE_I  in  1; CFG_HSCALE_MODE_I / CFG_VSCALE_MODE_I  in  2 each  (0 bypass, 1 /2, 2 /4, 3 illegal).
REQ-008 CFG_UPDATE_I  in  1  one-cycle pulse requesting shadow load at next VS edge.
REQ-009 IN_BEAT_I  in  1  scaler upstream FIFO read strobe; OUT_BEAT_I  in  1  scaler output FIFO write strobe.
REQ-010 SCALE_ENABLE_O, HSCALE_MODE_O[1:0], VSCALE_MODE_O[1:0], HACTIVE_O[15:0], VACTIVE_O[15:0]  out  active shadow config driving the scaler.
REQ-011 LINE_BEATS_O[15:0], OUT_HACTIVE_O[15:0], OUT_VACTIVE_O[15:0]  out  derived geometry.
REQ-012 FRAME_ACTIVE_O  out  1; FRAME_DONE_O  out  1 (one-cycle pulse); CFG_ERR_O, CNT_ERR_O  out  1 (sticky).
REQ-013 IN_BEAT_CNT_O, OUT_BEAT_CNT_O  out  C_CNT_WIDTH  live per-frame beat counts.

Function
REQ-014 VS edge = VS_I & ~vs_d, vs_d registered VS_I; evaluated combinationally in the same cycle.
REQ-015 CFG_UPDATE_I sets a pending flag; on VS edge with pending set (or CFG_UPDATE_I asserted that same cycle) the candidate config is validated and loaded; pending clears.
REQ-016 Candidate valid iff: modes != 3; HACTIVE != 0, VACTIVE != 0; HACTIVE divisible by C_IN_PORT_NUM*hdiv; VACTIVE divisible by vdiv; hdiv = 2^HSCALE_MODE, vdiv = 2^VSCALE_MODE when enabled, else 1/1.
REQ-017 Invalid candidate: shadow unchanged, CFG_ERR_O set; a later valid load clears CFG_ERR_O.
REQ-018 Shadow and derived outputs change on the clock edge at which the VS edge is seen; never mid-frame.
REQ-019 LINE_BEATS_O = HACTIVE/C_IN_PORT_NUM; OUT_HACTIVE_O = HACTIVE/hdiv; OUT_VACTIVE_O = VACTIVE/vdiv; divisions are shifts.
REQ-020 Expected in beats = LINE_BEATS*VACTIVE; expected out beats = (OUT_HACTIVE/C_IN_PORT_NUM)*OUT_VACTIVE; both registered one cycle after load, in C_CNT_WIDTH bits.
REQ-021 FSM states IDLE, RUN, DONE; reset -> IDLE; any VS edge -> RUN with both counters cleared to 0.
REQ-022 RUN: each strobe increments its counter by 1, saturating at all-ones; when both counts equal expected -> DONE, FRAME_DONE_O pulses 1 cycle.
REQ-023 DONE: any further IN_BEAT_I or OUT_BEAT_I sets CNT_ERR_O (overrun); counters still increment.
REQ-024 VS edge while in RUN (incomplete frame) sets CNT_ERR_O (underrun), no FRAME_DONE_O.
REQ-025 Strobes coincident with a VS edge are discarded (counters load 0).
REQ-026 FRAME_ACTIVE_O = 1 in RUN, else 0.
REQ-027 CNT_ERR_O clears only on reset or on a VS edge with CFG_UPDATE pending and valid.

Reset
REQ-028 RST_I high: state IDLE, all outputs 0, shadow 0 (scaler bypass), pending/vs_d/sticky flags cleared; takes precedence over VS edge.
REQ-029 Reset mid-frame: counters and FRAME_DONE_O cleared next edge; first VS edge after release loads config only if CFG_UPDATE_I pulsed after release.

Structure
REQ-030 Shared package scaler_pkg: mode encodings, FSM state constants, C_IN_PORT_NUM default.
REQ-031 One sub-module scaler_cfg_calc: combinational validity check and derived geometry from candidate config.

Verification
REQ-032 Valid load: 1920x1080, enable 1, modes 1/1, update + VS -> LINE_BEATS 120, OUT 960x540, expected in 129600, out 32400, CFG_ERR 0.
REQ-033 Full frame modes 2/2: 129600 IN_BEAT, 8100 OUT_BEAT -> FRAME_DONE one pulse, state DONE, CNT_ERR 0.
REQ-034 Invalid: HACTIVE 1000, mode 1, update + VS -> CFG_ERR 1, shadow retains previous 1920x1080.
REQ-035 Underrun: VS edge after 1000 IN_BEAT in RUN -> CNT_ERR 1, counters 0, no FRAME_DONE.
REQ-036 Overrun: one extra OUT_BEAT in DONE -> CNT_ERR 1; VS edge with IN_BEAT same cycle -> IN_BEAT_CNT 0.
REQ-037 RST_I mid-RUN at beat 500 -> all outputs 0 next cycle, state IDLE.

Source files
------------

// File: rtl/scaler_pkg.sv
// Shared definitions for the scaler frame controller: mode encodings, FSM states
// and the default input-port width.
package scaler_pkg;

  localparam int unsigned C_IN_PORT_NUM_DEF = 16;

  typedef enum logic [1:0] {
    MODE_BYPASS  = 2'd0,
    MODE_DIV2    = 2'd1,
    MODE_DIV4    = 2'd2,
    MODE_ILLEGAL = 2'd3
  } scale_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } frame_state_t;

  // Shift amount for a scale mode; a disabled scaler never divides.
  function automatic logic [1:0] mode_shift(input logic enable, input logic [1:0] mode);
    return enable ? mode : 2'd0;
  endfunction

endpackage

// File: rtl/scaler_cfg_calc.sv
// Combinational validity check and derived output geometry for a candidate
// scaler configuration.
module scaler_cfg_calc
  import scaler_pkg::*;
#(
  parameter int unsigned C_IN_PORT_NUM = C_IN_PORT_NUM_DEF
) (
  input  logic        scale_enable,
  input  logic [1:0]  hmode,
  input  logic [1:0]  vmode,
  input  logic [15:0] hactive,
  input  logic [15:0] vactive,
  output logic        valid,
  output logic [15:0] line_beats,
  output logic [15:0] out_hactive,
  output logic [15:0] out_vactive
);

  localparam int unsigned PORT_SHIFT = $clog2(C_IN_PORT_NUM);

  logic [1:0]  hshift;
  logic [1:0]  vshift;
  logic [31:0] hmask;
  logic [31:0] vmask;

  always_comb begin
    hshift = mode_shift(scale_enable, hmode);
    vshift = mode_shift(scale_enable, vmode);
    // Divisibility by a power of two reduces to the low bits being zero.
    hmask  = (32'd1 << (PORT_SHIFT + 32'(hshift))) - 32'd1;
    vmask  = (32'd1 << vshift) - 32'd1;
    valid  = (hmode != MODE_ILLEGAL) && (vmode != MODE_ILLEGAL) &&
             (hactive != '0) && (vactive != '0) &&
             ((32'(hactive) & hmask) == '0) && ((32'(vactive) & vmask) == '0);
    line_beats  = hactive >> PORT_SHIFT;
    out_hactive = hactive >> hshift;
    out_vactive = vactive >> vshift;
  end

endmodule

// File: rtl/scaler_frame_ctrl.sv
// Frame-level controller for the scaler: shadows configuration at VS edges and
// tracks per-frame input/output beat counts against the expected geometry.
module scaler_frame_ctrl
  import scaler_pkg::*;
#(
  parameter int unsigned C_IN_PORT_NUM = C_IN_PORT_NUM_DEF,
  parameter int unsigned C_CNT_WIDTH   = 32
) (
  input  logic                   CLK_I,
  input  logic                   RST_I,
  input  logic                   VS_I,
  input  logic [15:0]            CFG_HACTIVE_I,
  input  logic [15:0]            CFG_VACTIVE_I,
  input  logic                   CFG_SCALE_ENABLE_I,
  input  logic [1:0]             CFG_HSCALE_MODE_I,
  input  logic [1:0]             CFG_VSCALE_MODE_I,
  input  logic                   CFG_UPDATE_I,
  input  logic                   IN_BEAT_I,
  input  logic                   OUT_BEAT_I,
  output logic                   SCALE_ENABLE_O,
  output logic [1:0]             HSCALE_MODE_O,
  output logic [1:0]             VSCALE_MODE_O,
  output logic [15:0]            HACTIVE_O,
  output logic [15:0]            VACTIVE_O,
  output logic [15:0]            LINE_BEATS_O,
  output logic [15:0]            OUT_HACTIVE_O,
  output logic [15:0]            OUT_VACTIVE_O,
  output logic                   FRAME_ACTIVE_O,
  output logic                   FRAME_DONE_O,
  output logic                   CFG_ERR_O,
  output logic                   CNT_ERR_O,
  output logic [C_CNT_WIDTH-1:0] IN_BEAT_CNT_O,
  output logic [C_CNT_WIDTH-1:0] OUT_BEAT_CNT_O
);

  localparam int unsigned PORT_SHIFT = $clog2(C_IN_PORT_NUM);

  frame_state_t           state_q, state_d;
  logic                   vs_d;
  logic                   pending;
  logic                   cfg_err_q;
  logic                   cnt_err_q;
  logic                   done_q, done_d;
  logic                   underrun, overrun;
  logic [C_CNT_WIDTH-1:0] in_cnt_q, in_cnt_d, in_inc;
  logic [C_CNT_WIDTH-1:0] out_cnt_q, out_cnt_d, out_inc;
  logic [C_CNT_WIDTH-1:0] exp_in_q, exp_out_q;
  logic                   exp_stale_q;

  logic                   en_q;
  logic [1:0]             hmode_q, vmode_q;
  logic [15:0]            hactive_q, vactive_q;
  logic [15:0]            line_beats_q, out_h_q, out_v_q;

  logic                   cand_valid;
  logic [15:0]            cand_line_beats, cand_out_h, cand_out_v;
  logic                   vs_edge, load_req, load_ok;

  scaler_cfg_calc #(
    .C_IN_PORT_NUM(C_IN_PORT_NUM)
  ) u_cfg_calc (
    .scale_enable(CFG_SCALE_ENABLE_I),
    .hmode       (CFG_HSCALE_MODE_I),
    .vmode       (CFG_VSCALE_MODE_I),
    .hactive     (CFG_HACTIVE_I),
    .vactive     (CFG_VACTIVE_I),
    .valid       (cand_valid),
    .line_beats  (cand_line_beats),
    .out_hactive (cand_out_h),
    .out_vactive (cand_out_v)
  );

  assign vs_edge  = VS_I & ~vs_d;
  assign load_req = vs_edge & (pending | CFG_UPDATE_I);
  assign load_ok  = load_req & cand_valid;
  assign in_inc   = (in_cnt_q  == '1) ? in_cnt_q  : in_cnt_q  + C_CNT_WIDTH'(1);
  assign out_inc  = (out_cnt_q == '1) ? out_cnt_q : out_cnt_q + C_CNT_WIDTH'(1);

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    done_d    = 1'b0;
    underrun  = 1'b0;
    overrun   = 1'b0;
    if (vs_edge) begin
      state_d   = ST_RUN;
      in_cnt_d  = '0;
      out_cnt_d = '0;
      underrun  = (state_q == ST_RUN);
    end else begin
      case (state_q)
        ST_RUN: begin
          if (IN_BEAT_I)  in_cnt_d  = in_inc;
          if (OUT_BEAT_I) out_cnt_d = out_inc;
          // Expected totals lag a config load by one cycle; skip that cycle.
          if (!exp_stale_q && in_cnt_d == exp_in_q && out_cnt_d == exp_out_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
        ST_DONE: begin
          if (IN_BEAT_I)  in_cnt_d  = in_inc;
          if (OUT_BEAT_I) out_cnt_d = out_inc;
          overrun = IN_BEAT_I | OUT_BEAT_I;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q      <= ST_IDLE;
      vs_d         <= 1'b0;
      pending      <= 1'b0;
      cfg_err_q    <= 1'b0;
      cnt_err_q    <= 1'b0;
      done_q       <= 1'b0;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      exp_in_q     <= '0;
      exp_out_q    <= '0;
      exp_stale_q  <= 1'b0;
      en_q         <= 1'b0;
      hmode_q      <= '0;
      vmode_q      <= '0;
      hactive_q    <= '0;
      vactive_q    <= '0;
      line_beats_q <= '0;
      out_h_q      <= '0;
      out_v_q      <= '0;
    end else begin
      vs_d        <= VS_I;
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      done_q      <= done_d;
      exp_stale_q <= load_ok;
      exp_in_q    <= C_CNT_WIDTH'(32'(line_beats_q) * 32'(vactive_q));
      exp_out_q   <= C_CNT_WIDTH'(32'(out_h_q >> PORT_SHIFT) * 32'(out_v_q));

      if (vs_edge)           pending <= 1'b0;
      else if (CFG_UPDATE_I) pending <= 1'b1;

      if (load_req) begin
        if (cand_valid) begin
          en_q         <= CFG_SCALE_ENABLE_I;
          hmode_q      <= CFG_HSCALE_MODE_I;
          vmode_q      <= CFG_VSCALE_MODE_I;
          hactive_q    <= CFG_HACTIVE_I;
          vactive_q    <= CFG_VACTIVE_I;
          line_beats_q <= cand_line_beats;
          out_h_q      <= cand_out_h;
          out_v_q      <= cand_out_v;
          cfg_err_q    <= 1'b0;
        end else begin
          cfg_err_q    <= 1'b1;
        end
      end

      // An underrun of the closing frame is reported even if a valid load lands on the same edge.
      if (underrun || overrun) cnt_err_q <= 1'b1;
      else if (load_ok)        cnt_err_q <= 1'b0;
    end
  end

  assign SCALE_ENABLE_O = en_q;
  assign HSCALE_MODE_O  = hmode_q;
  assign VSCALE_MODE_O  = vmode_q;
  assign HACTIVE_O      = hactive_q;
  assign VACTIVE_O      = vactive_q;
  assign LINE_BEATS_O   = line_beats_q;
  assign OUT_HACTIVE_O  = out_h_q;
  assign OUT_VACTIVE_O  = out_v_q;
  assign FRAME_ACTIVE_O = (state_q == ST_RUN);
  assign FRAME_DONE_O   = done_q;
  assign CFG_ERR_O      = cfg_err_q;
  assign CNT_ERR_O      = cnt_err_q;
  assign IN_BEAT_CNT_O  = in_cnt_q;
  assign OUT_BEAT_CNT_O = out_cnt_q;

endmodule

// File: tb/tb_scaler_frame_ctrl.sv
// Directed self-checking bench for scaler_frame_ctrl: config load/reject,
// full frame, underrun, overrun and mid-frame reset.
module tb_scaler_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vs = 1'b0;
  logic [15:0] cfg_h = '0;
  logic [15:0] cfg_v = '0;
  logic        cfg_en = 1'b0;
  logic [1:0]  cfg_hm = '0;
  logic [1:0]  cfg_vm = '0;
  logic        cfg_upd = 1'b0;
  logic        in_beat = 1'b0;
  logic        out_beat = 1'b0;

  logic        scale_en;
  logic [1:0]  hmode, vmode;
  logic [15:0] hactive, vactive, line_beats, out_h, out_v;
  logic        frame_active, frame_done, cfg_err, cnt_err;
  logic [31:0] in_cnt, out_cnt;

  int n_assert = 0;
  int n_fail = 0;
  int done_seen = 0;
  int d0;

  scaler_frame_ctrl #(
    .C_IN_PORT_NUM(16),
    .C_CNT_WIDTH  (32)
  ) dut (
    .CLK_I             (clk),
    .RST_I             (rst),
    .VS_I              (vs),
    .CFG_HACTIVE_I     (cfg_h),
    .CFG_VACTIVE_I     (cfg_v),
    .CFG_SCALE_ENABLE_I(cfg_en),
    .CFG_HSCALE_MODE_I (cfg_hm),
    .CFG_VSCALE_MODE_I (cfg_vm),
    .CFG_UPDATE_I      (cfg_upd),
    .IN_BEAT_I         (in_beat),
    .OUT_BEAT_I        (out_beat),
    .SCALE_ENABLE_O    (scale_en),
    .HSCALE_MODE_O     (hmode),
    .VSCALE_MODE_O     (vmode),
    .HACTIVE_O         (hactive),
    .VACTIVE_O         (vactive),
    .LINE_BEATS_O      (line_beats),
    .OUT_HACTIVE_O     (out_h),
    .OUT_VACTIVE_O     (out_v),
    .FRAME_ACTIVE_O    (frame_active),
    .FRAME_DONE_O      (frame_done),
    .CFG_ERR_O         (cfg_err),
    .CNT_ERR_O         (cnt_err),
    .IN_BEAT_CNT_O     (in_cnt),
    .OUT_BEAT_CNT_O    (out_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) done_seen++;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    tick(2);
    chk("rst_frame_active", frame_active, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_cnt_err", cnt_err, 0);
    chk("rst_line_beats", line_beats, 0);
    chk("rst_in_cnt", in_cnt, 0);
    chk("rst_hactive", hactive, 0);
    rst = 1'b0;
    tick(1);

    // Valid load 1920x1080, /2 x /2
    cfg_h = 16'd1920; cfg_v = 16'd1080; cfg_en = 1'b1; cfg_hm = 2'd1; cfg_vm = 2'd1;
    cfg_upd = 1'b1; tick(1); cfg_upd = 1'b0;
    vs = 1'b1; tick(1);
    chk("load_line_beats", line_beats, 120);
    chk("load_out_h", out_h, 960);
    chk("load_out_v", out_v, 540);
    chk("load_hactive", hactive, 1920);
    chk("load_vactive", vactive, 1080);
    chk("load_scale_en", scale_en, 1);
    chk("load_hmode", hmode, 1);
    chk("load_cfg_err", cfg_err, 0);
    chk("load_frame_active", frame_active, 1);

    // Underrun after 1000 input beats
    d0 = done_seen;
    in_beat = 1'b1; tick(1000); in_beat = 1'b0;
    chk("under_in_cnt", in_cnt, 1000);
    vs = 1'b0; tick(1);
    vs = 1'b1; tick(1);
    chk("under_cnt_err", cnt_err, 1);
    chk("under_in_cnt0", in_cnt, 0);
    chk("under_out_cnt0", out_cnt, 0);
    chk("under_active", frame_active, 1);
    chk("under_no_done", done_seen - d0, 0);

    // Invalid candidate: 1000 not divisible by 32
    cfg_h = 16'd1000;
    cfg_upd = 1'b1; tick(1); cfg_upd = 1'b0;
    vs = 1'b0; tick(1);
    vs = 1'b1; tick(1);
    chk("inval_cfg_err", cfg_err, 1);
    chk("inval_hactive", hactive, 1920);
    chk("inval_line_beats", line_beats, 120);
    chk("inval_out_h", out_h, 960);

    // Reset mid-frame at beat 500, with an update pulse before reset
    cfg_h = 16'd256; cfg_v = 16'd64; cfg_hm = 2'd2; cfg_vm = 2'd2;
    in_beat = 1'b1; tick(500); in_beat = 1'b0;
    chk("mid_in_cnt", in_cnt, 500);
    cfg_upd = 1'b1; tick(1); cfg_upd = 1'b0;
    vs = 1'b0; rst = 1'b1; tick(1);
    chk("mrst_active", frame_active, 0);
    chk("mrst_in_cnt", in_cnt, 0);
    chk("mrst_cnt_err", cnt_err, 0);
    chk("mrst_cfg_err", cfg_err, 0);
    chk("mrst_hactive", hactive, 0);
    chk("mrst_line_beats", line_beats, 0);
    chk("mrst_scale_en", scale_en, 0);
    chk("mrst_done", frame_done, 0);
    rst = 1'b0; tick(1);
    vs = 1'b1; tick(1);
    chk("post_rst_noload", hactive, 0);
    chk("post_rst_active", frame_active, 1);
    tick(2);

    // Full reduced frame 256x64, /4 x /4: 1024 in beats, 64 out beats
    vs = 1'b0; cfg_upd = 1'b1; tick(1); cfg_upd = 1'b0;
    vs = 1'b1; tick(1);
    chk("full_line_beats", line_beats, 16);
    chk("full_out_h", out_h, 64);
    chk("full_out_v", out_v, 16);
    chk("full_hmode", hmode, 2);
    chk("full_cfg_err", cfg_err, 0);
    chk("full_cnt_err0", cnt_err, 0);
    d0 = done_seen;
    for (int i = 0; i < 1024; i++) begin
      in_beat = 1'b1;
      out_beat = (i < 64);
      tick(1);
    end
    in_beat = 1'b0; out_beat = 1'b0;
    chk("full_done_pulse", frame_done, 1);
    chk("full_state_done", frame_active, 0);
    chk("full_in_cnt", in_cnt, 1024);
    chk("full_out_cnt", out_cnt, 64);
    chk("full_cnt_err", cnt_err, 0);
    tick(1);
    chk("full_done_low", frame_done, 0);
    chk("full_one_pulse", done_seen - d0, 1);

    // Overrun in DONE, then VS edge with coincident IN_BEAT and a valid update
    out_beat = 1'b1; tick(1); out_beat = 1'b0;
    chk("over_cnt_err", cnt_err, 1);
    chk("over_out_cnt", out_cnt, 65);
    chk("over_still_done", frame_active, 0);
    vs = 1'b0; tick(1);
    vs = 1'b1; in_beat = 1'b1; cfg_upd = 1'b1; tick(1);
    in_beat = 1'b0; cfg_upd = 1'b0;
    chk("vs_beat_in_cnt", in_cnt, 0);
    chk("vs_load_clr_cnt_err", cnt_err, 0);
    chk("vs_active", frame_active, 1);
    chk("vs_cfg_err", cfg_err, 0);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
